// File: rtl/rect_ctl.sv
// Per-frame motion controller for a dropping rectangle: constant acceleration, damped floor bounce.
// Position updates only on the vblnk rising edge, so every frame sees a stable position.
module rect_ctl #(
    parameter int unsigned SCREEN_H   = 600,
    parameter int unsigned RECT_H     = 64,
    parameter int unsigned X_INIT     = 368,
    parameter int unsigned Y_INIT     = 0,
    parameter int unsigned ACCEL      = 1,
    parameter int unsigned VMAX       = 32,
    parameter int unsigned DAMP_SHIFT = 1,
    parameter int unsigned STOP_VEL   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblnk,
    input  logic        start,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        busy,
    output logic        done
);

    localparam int unsigned FLOOR = SCREEN_H - RECT_H;

    typedef enum logic [1:0] {StIdle, StFall, StUp, StStop} state_e;

    state_e      state_q, state_d;
    logic [11:0] vel_q, vel_d;
    logic [11:0] ypos_q, ypos_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        vblnk_d, start_d;

    logic        tick, start_re;
    logic [12:0] pos_sum, vel_inc;
    logic [11:0] vel_damp;

    assign tick     = vblnk & ~vblnk_d;
    assign start_re = start & ~start_d;

    // 13-bit sums so an overflow past the floor or VMAX is never lost before the clamp
    assign pos_sum  = {1'b0, ypos_q} + {1'b0, vel_q};
    assign vel_inc  = {1'b0, vel_q} + 13'(ACCEL);
    assign vel_damp = vel_q - (vel_q >> DAMP_SHIFT);

    always_comb begin
        state_d = state_q;
        vel_d   = vel_q;
        ypos_d  = ypos_q;
        unique case (state_q)
            StIdle: begin
                if (start_re) begin
                    state_d = StFall;
                    vel_d   = '0;
                    ypos_d  = 12'(Y_INIT);
                end
            end
            StFall: begin
                if (tick) begin
                    if (pos_sum < 13'(FLOOR)) begin
                        ypos_d = pos_sum[11:0];
                        vel_d  = (vel_inc > 13'(VMAX)) ? 12'(VMAX) : vel_inc[11:0];
                    end else begin
                        ypos_d = 12'(FLOOR);
                        if (vel_damp > 12'(STOP_VEL)) begin
                            state_d = StUp;
                            vel_d   = vel_damp;
                        end else begin
                            state_d = StStop;
                            vel_d   = '0;
                        end
                    end
                end
            end
            StUp: begin
                if (tick) begin
                    ypos_d = (vel_q > ypos_q) ? 12'd0 : ypos_q - vel_q;
                    if (vel_q <= 12'(ACCEL)) begin
                        vel_d   = '0;
                        state_d = StFall;
                    end else begin
                        vel_d = vel_q - 12'(ACCEL);
                    end
                end
            end
            StStop: begin
                ypos_d = 12'(FLOOR);
                if (start_re) begin
                    state_d = StIdle;
                    ypos_d  = 12'(Y_INIT);
                    vel_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        // Flags follow the next state so they flip in the same cycle as the state register
        busy_d = (state_d == StFall) || (state_d == StUp);
        done_d = (state_d == StStop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vel_q   <= '0;
            ypos_q  <= 12'(Y_INIT);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vblnk_d <= 1'b0;
            start_d <= 1'b0;
        end else begin
            state_q <= state_d;
            vel_q   <= vel_d;
            ypos_q  <= ypos_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vblnk_d <= vblnk;
            start_d <= start;
        end
    end

    assign xpos = 12'(X_INIT);
    assign ypos = ypos_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_rect_ctl.sv
// Bench for rect_ctl: frame-level model of the bounce physics compared every settled cycle,
// two builds (default damping and DAMP_SHIFT=0) driven by the same stimulus.
module tb_rect_ctl;

    logic        clk = 1'b0, clk_en = 1'b0, rst_n = 1'b0, vblnk = 1'b0, start = 1'b0;
    logic [11:0] xpos_a, ypos_a, xpos_b, ypos_b;
    logic        busy_a, done_a, busy_b, done_b;

    int n_asrt = 0, n_fail = 0, quiet = 0;
    bit chk_on = 0;

    // Model: st 0=idle 1=falling 2=rising 3=stopped
    int m_st[2], m_y[2], m_v[2];
    int m_ds[2] = '{1, 0};
    int exp3[4] = '{0, 1, 3, 6};

    always #5 clk = clk_en ? ~clk : clk;

    rect_ctl u_dut_a (
        .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .start(start),
        .xpos(xpos_a), .ypos(ypos_a), .busy(busy_a), .done(done_a)
    );

    rect_ctl #(.DAMP_SHIFT(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .vblnk(vblnk), .start(start),
        .xpos(xpos_b), .ypos(ypos_b), .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_asrt++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0;
            m_y[i]  = 0;
            m_v[i]  = 0;
        end
    endfunction

    function void model_apply(input bit t, input bit s);
        int sum, d;
        for (int i = 0; i < 2; i++) begin
            case (m_st[i])
                0: if (s) begin m_st[i] = 1; m_v[i] = 0; m_y[i] = 0; end
                1: if (t) begin
                    sum = m_y[i] + m_v[i];
                    if (sum < 536) begin
                        m_y[i] = sum;
                        m_v[i] = (m_v[i] + 1 > 32) ? 32 : m_v[i] + 1;
                    end else begin
                        m_y[i] = 536;
                        d = m_v[i] - (m_v[i] >> m_ds[i]);
                        if (d > 2) begin m_st[i] = 2; m_v[i] = d; end
                        else begin m_st[i] = 3; m_v[i] = 0; end
                    end
                end
                2: if (t) begin
                    m_y[i] = (m_v[i] > m_y[i]) ? 0 : m_y[i] - m_v[i];
                    if (m_v[i] <= 1) begin m_v[i] = 0; m_st[i] = 1; end
                    else m_v[i] = m_v[i] - 1;
                end
                default: if (s) begin m_st[i] = 0; m_y[i] = 0; m_v[i] = 0; end
            endcase
        end
    endfunction

    always @(posedge clk) begin
        #2;
        if (chk_on) begin
            if (quiet > 0) quiet--;
            else begin
                chk("a_xpos", int'(xpos_a), 368);
                chk("a_ypos", int'(ypos_a), m_y[0]);
                chk("a_busy", int'(busy_a), int'(m_st[0] == 1 || m_st[0] == 2));
                chk("a_done", int'(done_a), int'(m_st[0] == 3));
                chk("b_ypos", int'(ypos_b), m_y[1]);
                chk("b_busy", int'(busy_b), int'(m_st[1] == 1 || m_st[1] == 2));
                chk("b_done", int'(done_b), int'(m_st[1] == 3));
            end
        end
    end

    // One frame: optional vblnk pulse plus a new start level, then settle
    task automatic step(input bit t, input bit s);
        bit se;
        @(negedge clk);
        se = s && !start;
        vblnk = t;
        start = s;
        model_apply(t, se);
        quiet = 2;
        repeat (3) @(negedge clk);
        vblnk = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_to_done(input bit s);
        int n = 0;
        while (!done_a && n < 400) begin
            step(1'b1, s);
            n++;
        end
        chk("drop_completes", int'(done_a), 1);
    endtask

    initial begin
        model_reset();
        #3;
        chk("rst_xpos", int'(xpos_a), 368);
        chk("rst_ypos", int'(ypos_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        clk_en = 1'b1;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        repeat (5) step(1'b1, 1'b0);
        chk("idle_ypos", int'(ypos_a), 0);
        chk("idle_busy", int'(busy_a), 0);

        step(1'b0, 1'b1);
        chk("start_busy", int'(busy_a), 1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0);
            chk("fall_seq", int'(ypos_a), exp3[k]);
        end
        for (int k = 5; k <= 33; k++) step(1'b1, 1'b0);
        chk("tick33_ypos", int'(ypos_a), 528);
        step(1'b1, 1'b0);
        chk("impact_ypos", int'(ypos_a), 536);
        chk("impact_busy", int'(busy_a), 1);
        chk("impact_done", int'(done_a), 0);
        chk("noDamp_ypos", int'(ypos_b), 536);
        chk("noDamp_done", int'(done_b), 1);
        step(1'b1, 1'b0);
        chk("rebound_ypos", int'(ypos_a), 520);

        run_to_done(1'b0);
        chk("end_ypos", int'(ypos_a), 536);
        chk("end_busy", int'(busy_a), 0);
        repeat (3) step(1'b1, 1'b0);
        chk("stop_hold", int'(ypos_a), 536);
        chk("stop_done", int'(done_a), 1);
        step(1'b0, 1'b1);
        chk("rearm_ypos", int'(ypos_a), 0);
        chk("rearm_done", int'(done_a), 0);

        // tick and start rising together in idle: transition only, no motion
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("coinc_busy", int'(busy_a), 1);
        chk("coinc_ypos", int'(ypos_a), 0);
        step(1'b1, 1'b0);
        chk("coinc_t1", int'(ypos_a), 0);
        step(1'b1, 1'b0);
        chk("coinc_t2", int'(ypos_a), 1);

        run_to_done(1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        run_to_done(1'b1);
        repeat (5) step(1'b1, 1'b1);
        chk("held_start_once", int'(done_a), 1);
        chk("held_start_ypos", int'(ypos_a), 536);

        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b0);
        chk("pre_rst_ypos", int'(ypos_a), 45);
        start = 1'b0;
        #3;
        rst_n = 1'b0;
        model_reset();
        quiet = 0;
        #1;
        chk("async_rst_ypos", int'(ypos_a), 0);
        chk("async_rst_busy", int'(busy_a), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 5) == 0) ? ~start : start);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
